// File: rtl/battleship_pkg.sv
// ---------------------------------------------------------------------------
// battleship_pkg
// Shared definitions for the fleet placement logic: board size, the length of
// each ship in placement order, the placement FSM states and the encoding of
// the direction a ship grows in once its second cell is placed.
// ---------------------------------------------------------------------------
package battleship_pkg;

    localparam int BOARD_CELLS = 36;
    localparam int SHIP_COUNT  = 3;

    // Ship lengths in the order the ships are placed.
    localparam logic [2:0] SHIP_LEN [SHIP_COUNT] = '{3'd3, 3'd2, 3'd2};

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        NEXT,
        DONE
    } state_t;

    // STEP_NONE means the ship has at most one cell so far and may still
    // grow in any of the four orthogonal directions.
    typedef enum logic [2:0] {
        STEP_NONE,
        STEP_RIGHT,
        STEP_LEFT,
        STEP_DOWN,
        STEP_UP
    } step_t;

    // Length lookup that stays well defined for a ship index past the fleet.
    function automatic logic [2:0] ship_len(input logic [1:0] idx);
        if (int'(idx) < SHIP_COUNT) begin
            return SHIP_LEN[idx];
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/cell_step_check.sv
// ---------------------------------------------------------------------------
// cell_step_check
// Decides whether key_index may extend a ship whose most recent cell is
// last. With one cell placed (one_cell=1) any orthogonal neighbour is legal
// and new_step reports the direction it establishes. Otherwise only the cell
// one further step along the established direction is legal.
// Horizontal moves never wrap from one row into the next.
//
// Ports:
//   last      - cell index of the most recently placed cell
//   key_index - candidate cell index
//   step      - direction already fixed for this ship
//   one_cell  - high when exactly one cell of the ship is placed
//   legal     - candidate is an acceptable continuation
//   new_step  - direction the ship follows if the candidate is accepted
// ---------------------------------------------------------------------------
module cell_step_check
    import battleship_pkg::*;
#(
    parameter int BOARD_N = 6
) (
    input  logic [5:0] last,
    input  logic [5:0] key_index,
    input  step_t      step,
    input  logic       one_cell,
    output logic       legal,
    output step_t      new_step
);

    int   last_i;
    int   key_i;
    int   last_row;
    int   last_col;
    logic ok_right;
    logic ok_left;
    logic ok_down;
    logic ok_up;

    // Work out which of the four neighbours of last the candidate is, if any.
    // The row/column tests keep a move from running off an edge of the board.
    always_comb begin
        last_i   = int'(last);
        key_i    = int'(key_index);
        last_row = last_i / BOARD_N;
        last_col = last_i % BOARD_N;
        ok_right = (last_col < BOARD_N - 1) && (key_i == last_i + 1);
        ok_left  = (last_col > 0)           && (key_i == last_i - 1);
        ok_down  = (last_row < BOARD_N - 1) && (key_i == last_i + BOARD_N);
        ok_up    = (last_row > 0)           && (key_i == last_i - BOARD_N);
    end

    // With a single cell any neighbour is fine and fixes the direction;
    // afterwards the ship must keep growing in that same direction.
    always_comb begin
        legal    = 1'b0;
        new_step = step;
        if (one_cell) begin
            if (ok_right) begin
                legal    = 1'b1;
                new_step = STEP_RIGHT;
            end else if (ok_left) begin
                legal    = 1'b1;
                new_step = STEP_LEFT;
            end else if (ok_down) begin
                legal    = 1'b1;
                new_step = STEP_DOWN;
            end else if (ok_up) begin
                legal    = 1'b1;
                new_step = STEP_UP;
            end
        end else begin
            case (step)
                STEP_RIGHT: legal = ok_right;
                STEP_LEFT:  legal = ok_left;
                STEP_DOWN:  legal = ok_down;
                STEP_UP:    legal = ok_up;
                default:    legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/placement_controller.sv
// ---------------------------------------------------------------------------
// placement_controller
// Collects key presses into straight ships of the lengths in SHIP_LEN,
// rejecting keys that are off the board, already used or not in line with
// the ship being built. A finished ship is merged into ships in one edge.
//
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   start       - begin placing the fleet (only honoured in IDLE)
//   key_valid   - key_index carries a cell selection this cycle
//   key_index   - selected cell, row*BOARD_N + col
//   cancel      - drop the ship in progress and restart it
//   ships       - committed ship cells
//   pending     - cells of the ship in progress
//   ship_num    - index of the ship being placed
//   cells_left  - cells still needed for the current ship
//   busy, done  - placing / fleet complete
//   err, commit - one-cycle pulses: key rejected / ship committed
// ---------------------------------------------------------------------------
module placement_controller
    import battleship_pkg::*;
#(
    parameter int NUM_SHIPS = 3,
    parameter int BOARD_N   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        key_valid,
    input  logic [5:0]  key_index,
    input  logic        cancel,
    output logic [35:0] ships,
    output logic [35:0] pending,
    output logic [1:0]  ship_num,
    output logic [2:0]  cells_left,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        commit
);

    state_t      state;
    state_t      state_nxt;
    step_t       step_q;
    step_t       step_nxt;
    step_t       cand_step;
    logic [5:0]  last_q;
    logic [5:0]  last_nxt;
    logic [35:0] ships_nxt;
    logic [35:0] pending_nxt;
    logic [1:0]  ship_num_nxt;
    logic [2:0]  cells_left_nxt;
    logic        err_nxt;
    logic        commit_nxt;
    logic [35:0] used_mask;
    logic [35:0] placed;
    logic [2:0]  left_after;
    logic        key_in_range;
    logic        occupied;
    logic        step_legal;
    logic        key_ok;

    // A key must land on the board and on a cell nobody is using yet; the
    // range test guards the bit select for indices past the last cell.
    assign used_mask    = ships | pending;
    assign key_in_range = key_index < 6'(BOARD_CELLS);
    assign occupied     = key_in_range && used_mask[key_index];

    cell_step_check #(
        .BOARD_N (BOARD_N)
    ) u_step_check (
        .last      (last_q),
        .key_index (key_index),
        .step      (step_q),
        .one_cell  (step_q == STEP_NONE),
        .legal     (step_legal),
        .new_step  (cand_step)
    );

    assign busy = (state == FIRST) || (state == NEXT);
    assign done = (state == DONE);

    // Next-state logic. Everything holds by default and the pulses drop; a
    // rejected key therefore only raises err. The last accepted key of a
    // ship folds pending straight into ships rather than through pending.
    always_comb begin
        state_nxt      = state;
        step_nxt       = step_q;
        last_nxt       = last_q;
        ships_nxt      = ships;
        pending_nxt    = pending;
        ship_num_nxt   = ship_num;
        cells_left_nxt = cells_left;
        err_nxt        = 1'b0;
        commit_nxt     = 1'b0;
        placed         = pending | (36'd1 << key_index);
        left_after     = cells_left - 3'd1;
        key_ok         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = FIRST;
                    ship_num_nxt   = 2'd0;
                    cells_left_nxt = ship_len(2'd0);
                    pending_nxt    = '0;
                    step_nxt       = STEP_NONE;
                end
            end
            FIRST, NEXT: begin
                if (cancel) begin
                    state_nxt      = FIRST;
                    pending_nxt    = '0;
                    cells_left_nxt = ship_len(ship_num);
                    step_nxt       = STEP_NONE;
                end else if (key_valid) begin
                    key_ok = key_in_range && !occupied &&
                             ((state == FIRST) || step_legal);
                    if (key_ok) begin
                        last_nxt = key_index;
                        step_nxt = (state == NEXT) ? cand_step : STEP_NONE;
                        if (left_after == 3'd0) begin
                            ships_nxt      = ships | placed;
                            pending_nxt    = '0;
                            commit_nxt     = 1'b1;
                            step_nxt       = STEP_NONE;
                            cells_left_nxt = 3'd0;
                            if (ship_num == 2'(NUM_SHIPS - 1)) begin
                                state_nxt = DONE;
                            end else begin
                                state_nxt      = FIRST;
                                ship_num_nxt   = ship_num + 2'd1;
                                cells_left_nxt = ship_len(ship_num + 2'd1);
                            end
                        end else begin
                            state_nxt      = NEXT;
                            pending_nxt    = placed;
                            cells_left_nxt = left_after;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State register; reset clears the board and any placement in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step_q     <= STEP_NONE;
            last_q     <= '0;
            ships      <= '0;
            pending    <= '0;
            ship_num   <= '0;
            cells_left <= '0;
            err        <= 1'b0;
            commit     <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_q     <= step_nxt;
            last_q     <= last_nxt;
            ships      <= ships_nxt;
            pending    <= pending_nxt;
            ship_num   <= ship_num_nxt;
            cells_left <= cells_left_nxt;
            err        <= err_nxt;
            commit     <= commit_nxt;
        end
    end

endmodule

// File: doc/placement_controller.md
PLACEMENT_CONTROLLER -- requirements
Module: placement_controller

Interface
REQ-001 The block SHALL have parameter NUM_SHIPS, default 3, meaning the number of ships in the fleet.
REQ-002 The block SHALL have parameter BOARD_N, default 6, meaning the board side; cell index = row*BOARD_N + col.
REQ-003 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a request to begin fleet placement.
REQ-006 The block SHALL have port key_valid, input, 1, meaning key_index is valid this cycle.
REQ-007 The block SHALL have port key_index, input, 6, meaning the selected cell index.
REQ-008 The block SHALL have port cancel, input, 1, meaning discard the ship currently being placed.
REQ-009 The block SHALL have port ships, output, 36, meaning the committed ship cells (1 = occupied).
REQ-010 The block SHALL have port pending, output, 36, meaning the cells of the ship in progress.
REQ-011 The block SHALL have port ship_num, output, 2, meaning the index of the ship being placed.
REQ-012 The block SHALL have port cells_left, output, 3, meaning the cells still needed for the current ship.
REQ-013 The block SHALL have ports busy, done, err and commit, each output, 1, meaning placing, fleet complete, key rejected (pulse) and ship committed (pulse).

Function
REQ-014 The FSM SHALL have states IDLE, FIRST, NEXT and DONE.
REQ-015 IDLE SHALL go to FIRST on start, setting ship_num=0 and cells_left=SHIP_LEN[0]; start in any other state SHALL be ignored.
REQ-016 In FIRST, an accepted key SHALL set its pending bit, store it as last, decrement cells_left and go to NEXT.
REQ-017 In NEXT, with exactly one pending cell, a key orthogonally adjacent to last SHALL be accepted and SHALL fix step to +1, -1, +BOARD_N or -BOARD_N.
REQ-018 In NEXT, with two or more pending cells, only last+step SHALL be accepted; a horizontal step that crosses a row boundary SHALL be rejected.
REQ-019 A key SHALL be rejected if key_index >= BOARD_N*BOARD_N, if its cell is set in ships or pending, or if it breaks REQ-017/REQ-018.
REQ-020 A rejected key SHALL leave all state unchanged and SHALL pulse err high for exactly one cycle, the cycle after the key.
REQ-021 When cells_left reaches 0, pending SHALL be ORed into ships, pending SHALL clear, and commit SHALL pulse for one cycle, all on the same edge.
REQ-022 After a commit, the FSM SHALL advance ship_num and return to FIRST, or go to DONE after the final ship.
REQ-023 cancel in FIRST or NEXT SHALL clear pending, restore cells_left=SHIP_LEN[ship_num] and go to FIRST.
REQ-024 cancel SHALL win over key_valid in the same cycle, and SHALL be ignored in IDLE and DONE.
REQ-025 key_valid SHALL be ignored without err in IDLE and DONE.
REQ-026 Each accepted key SHALL take effect on pending, cells_left and the state on the next rising edge (1-cycle latency).
REQ-027 busy SHALL be high in FIRST and NEXT; done SHALL be high in DONE, and DONE SHALL be held until reset.

Reset
REQ-028 reset SHALL asynchronously force IDLE, ships=0, pending=0, ship_num=0, cells_left=0, step=0, and busy/done/err/commit=0, including in the middle of placement.

Structure
REQ-029 The package battleship_pkg SHALL hold BOARD_CELLS=36, SHIP_LEN={3,2,2}, the FSM state encoding and the step encoding.
REQ-030 Adjacency and step legality SHALL be a combinational sub-module, cell_step_check, taking last, key_index, step and a one-cell flag and returning legal plus the new step.

Verification
REQ-031 start; keys 0,1,2 -> commit on the edge after key 2, ships=0x7, ship_num=1, cells_left=2.
REQ-032 In ship 1, keys 5 then 6 (row wrap) -> err pulse, pending=bit5 only, cells_left=1.
REQ-033 In ship 1, key 1 (occupied) -> err pulse, pending unchanged.
REQ-034 In ship 1, keys 10,16 then cancel together with key_valid on 22 -> pending=0, cells_left=2, state FIRST.
REQ-035 Full fleet: 0,1,2 / 10,16 / 30,31 -> done=1 and ships has bits {0,1,2,10,16,30,31} set.
REQ-036 Reset asserted after a key in NEXT -> all outputs 0, IDLE; the next key without start produces no err.
